// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with load scoreboard.
package regfile_pkg;

    localparam int BA_IDX       = 0;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    function automatic int addr_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, ALU write, load issue/return.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = addr_w(NUM_REGS)
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     ld_issue;
    logic [ADDR_W-1:0]        ld_issue_addr;
    logic                     ld_done;
    logic [ADDR_W-1:0]        ld_done_addr;
    logic [DATA_W-1:0]        ld_data;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     sb_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output ld_issue, ld_issue_addr, ld_done, ld_done_addr, ld_data,
        input  rd_data, rd_busy, busy_vec, sb_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  ld_issue, ld_issue_addr, ld_done, ld_done_addr, ld_data,
        output rd_data, rd_busy, busy_vec, sb_err
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding loads, with a registered protocol-error pulse.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_issue_i,
    input  logic [ADDR_W-1:0]   ld_issue_addr_i,
    input  logic                ld_done_i,
    input  logic [ADDR_W-1:0]   ld_done_addr_i,
    output logic [NUM_REGS-1:0] busy_vec_o,
    output logic                sb_err_o
);

    localparam logic [ADDR_W:0] NREGS_C = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                err_q;
    logic                err_d;
    logic                issue_ok_s;
    logic                done_ok_s;
    logic                same_reg_s;

    assign issue_ok_s = ({1'b0, ld_issue_addr_i} < NREGS_C);
    assign done_ok_s  = ({1'b0, ld_done_addr_i} < NREGS_C);
    assign same_reg_s = ld_done_i && (ld_done_addr_i == ld_issue_addr_i);

    // Busy next-state: issue beats done on the same register.
    always_comb begin
        busy_d = busy_q;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (ld_issue_i && issue_ok_s && (ld_issue_addr_i == ADDR_W'(n))) begin
                busy_d[n] = 1'b1;
            end else if (ld_done_i && done_ok_s && (ld_done_addr_i == ADDR_W'(n))) begin
                busy_d[n] = 1'b0;
            end else begin
                busy_d[n] = busy_q[n];
            end
        end
    end

    // Protocol error detection: double issue, orphan return, or out-of-range address.
    always_comb begin
        err_d = 1'b0;
        if (ld_issue_i && !issue_ok_s) begin
            err_d = 1'b1;
        end else if (ld_issue_i && busy_q[ld_issue_addr_i] && !same_reg_s) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
        if (ld_done_i && !done_ok_s) begin
            err_d = 1'b1;
        end else if (ld_done_i && !busy_q[ld_done_addr_i]) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign sb_err_o   = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with ALU and load-return write ports, optional write-to-read bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          NUM_REGS = DEF_NUM_REGS,
    parameter int          NUM_RD   = 2,
    parameter logic [15:0] BA_INIT  = 16'h0400,
    parameter bit          BYPASS   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    regfile_scoreboard_if.slave bus
);

    localparam int                ADDR_W  = addr_w(NUM_REGS);
    localparam logic [ADDR_W:0]   NREGS_C = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [DATA_W-1:0] BA_VAL  = DATA_W'(BA_INIT);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec_s;
    logic                sb_err_s;
    logic                wr_ok_s;
    logic                ld_ok_s;

    assign wr_ok_s = bus.wr_en   && ({1'b0, bus.wr_addr} < NREGS_C);
    assign ld_ok_s = bus.ld_done && ({1'b0, bus.ld_done_addr} < NREGS_C);

    // Write-priority mux: the ALU result wins over a colliding load return.
    always_comb begin
        for (int n = 0; n < NUM_REGS; n++) begin
            if (wr_ok_s && (bus.wr_addr == ADDR_W'(n))) begin
                regs_d[n] = bus.wr_data;
            end else if (ld_ok_s && (bus.ld_done_addr == ADDR_W'(n))) begin
                regs_d[n] = bus.ld_data;
            end else begin
                regs_d[n] = regs_q[n];
            end
        end
    end

    // Storage array; register 0 resets to the base address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= (n == BA_IDX) ? BA_VAL : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk             (clk),
        .rst             (rst),
        .ld_issue_i      (bus.ld_issue),
        .ld_issue_addr_i (bus.ld_issue_addr),
        .ld_done_i       (bus.ld_done),
        .ld_done_addr_i  (bus.ld_done_addr),
        .busy_vec_o      (busy_vec_s),
        .sb_err_o        (sb_err_s)
    );

    assign bus.busy_vec = busy_vec_s;
    assign bus.sb_err   = sb_err_s;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              in_rng_s;
        logic              wr_match_s;
        logic              ld_match_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s     = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign in_rng_s   = ({1'b0, addr_s} < NREGS_C);
        assign wr_match_s = BYPASS && bus.wr_en   && (bus.wr_addr == addr_s);
        assign ld_match_s = BYPASS && bus.ld_done && (bus.ld_done_addr == addr_s);

        // Read mux: a returning load hides the busy bit only when forwarding is on.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (!in_rng_s) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if (wr_match_s) begin
                data_s = bus.wr_data;
                busy_s = busy_vec_s[addr_s] & ~ld_match_s;
            end else if (ld_match_s) begin
                data_s = bus.ld_data;
                busy_s = 1'b0;
            end else begin
                data_s = regs_q[addr_s];
                busy_s = busy_vec_s[addr_s];
            end
        end

        assign bus.rd_data[p*DATA_W +: DATA_W] = data_s;
        assign bus.rd_busy[p]                  = busy_s;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: 8x16 bypassing instance driven from a vector table, 6-reg non-bypass instance by hand.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) ifa ();
    regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(6), .NUM_RD(3)) ifb ();

    regfile_scoreboard #(
        .DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BA_INIT(16'h0400), .BYPASS(1'b1)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));

    regfile_scoreboard #(
        .DATA_W(16), .NUM_REGS(6), .NUM_RD(3), .BA_INIT(16'h0400), .BYPASS(1'b0)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    typedef struct {
        logic        wr_en;   logic [2:0] wa; logic [15:0] wd;
        logic        li;      logic [2:0] ia;
        logic        ld;      logic [2:0] da; logic [15:0] ldd;
        logic [2:0]  ra0;     logic [2:0] ra1;
        logic [15:0] ed0;     logic [15:0] ed1;
        logic [1:0]  ebusy;   logic [7:0] ebv; logic eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic li, input logic [2:0] ia,
                                input logic ld, input logic [2:0] da, input logic [15:0] ldd,
                                input logic [2:0] ra0, input logic [2:0] ra1,
                                input logic [15:0] ed0, input logic [15:0] ed1,
                                input logic [1:0] eb, input logic [7:0] ebv, input logic eerr);
        vec_t v;
        v.wr_en = we; v.wa = wa; v.wd = wd; v.li = li; v.ia = ia;
        v.ld = ld; v.da = da; v.ldd = ldd; v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.ebusy = eb; v.ebv = ebv; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        ifa.wr_en = 1'b0; ifa.wr_addr = 3'd0; ifa.wr_data = 16'h0000;
        ifa.ld_issue = 1'b0; ifa.ld_issue_addr = 3'd0;
        ifa.ld_done = 1'b0; ifa.ld_done_addr = 3'd0; ifa.ld_data = 16'h0000;
    endtask

    task automatic idle_b();
        ifb.wr_en = 1'b0; ifb.wr_addr = 3'd0; ifb.wr_data = 16'h0000;
        ifb.ld_issue = 1'b0; ifb.ld_issue_addr = 3'd0;
        ifb.ld_done = 1'b0; ifb.ld_done_addr = 3'd0; ifb.ld_data = 16'h0000;
    endtask

    task automatic read_b(input logic [2:0] a, input logic [15:0] exp, input logic eb, input string name);
        ifb.rd_addr = {3{a}};
        #1;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("%s p%0d data", name, p), 32'(ifb.rd_data[p*16 +: 16]), 32'(exp));
            chk($sformatf("%s p%0d busy", name, p), 32'(ifb.rd_busy[p]), 32'(eb));
        end
    endtask

    initial begin
        // we wa wd li ia ld da ldd ra0 ra1 ed0 ed1 ebusy ebv eerr
        vecs.push_back(mk(1, 3, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 3, 0, 16'hBEEF, 16'h0400, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3, 5, 16'hBEEF, 16'h0000, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 5, 0, 0, 16'h0000, 3, 5, 16'hBEEF, 16'h0000, 2'b00, 8'h20, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3, 5, 16'hBEEF, 16'h0000, 2'b10, 8'h20, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 5, 16'h1234, 5, 5, 16'h1234, 16'h1234, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 5, 5, 16'h1234, 16'h1234, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 0, 0, 16'h0000, 2, 0, 16'h0000, 16'h0400, 2'b00, 8'h04, 0));
        vecs.push_back(mk(1, 2, 16'hAAAA, 0, 0, 1, 2, 16'h5555, 2, 2, 16'hAAAA, 16'hAAAA, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 2, 0, 16'hAAAA, 16'h0400, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 4, 0, 0, 16'h0000, 4, 0, 16'h0000, 16'h0400, 2'b00, 8'h10, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 4, 0, 0, 16'h0000, 4, 0, 16'h0000, 16'h0400, 2'b01, 8'h10, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4, 6, 16'h0000, 16'h0000, 2'b01, 8'h10, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 6, 16'h6666, 6, 4, 16'h6666, 16'h0000, 2'b10, 8'h10, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 6, 4, 16'h6666, 16'h0000, 2'b10, 8'h10, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 4, 1, 4, 16'h4444, 4, 6, 16'h4444, 16'h6666, 2'b00, 8'h10, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4, 4, 16'h4444, 16'h4444, 2'b11, 8'h10, 0));
        vecs.push_back(mk(1, 4, 16'h7777, 0, 0, 0, 0, 16'h0000, 4, 6, 16'h7777, 16'h6666, 2'b01, 8'h10, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 4, 16'h9999, 4, 4, 16'h9999, 16'h9999, 2'b00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 16'h1111, 0, 0, 0, 0, 16'h0000, 0, 4, 16'h1111, 16'h9999, 2'b00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 3, 16'h1111, 16'hBEEF, 2'b00, 8'h00, 0));

        rst_a = 1'b1; rst_b = 1'b1;
        idle_a(); idle_b();
        ifa.rd_addr = '0; ifb.rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state of both instances.
        chk("a reset busy_vec", 32'(ifa.busy_vec), 32'h0);
        chk("a reset sb_err", 32'(ifa.sb_err), 32'h0);
        chk("b reset busy_vec", 32'(ifb.busy_vec), 32'h0);
        chk("b reset sb_err", 32'(ifb.sb_err), 32'h0);
        for (int i = 0; i < 8; i++) begin
            ifa.rd_addr = {3'(i), 3'(i)};
            #1;
            chk($sformatf("a reset r%0d p0", i), 32'(ifa.rd_data[15:0]), (i == 0) ? 32'h0400 : 32'h0);
            chk($sformatf("a reset r%0d p1", i), 32'(ifa.rd_data[31:16]), (i == 0) ? 32'h0400 : 32'h0);
            chk($sformatf("a reset r%0d busy", i), 32'(ifa.rd_busy), 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            read_b(3'(i), (i == 0) ? 16'h0400 : 16'h0000, 1'b0, $sformatf("b reset r%0d", i));
        end

        // Table-driven vectors on the bypassing instance.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ifa.wr_en = vecs[i].wr_en; ifa.wr_addr = vecs[i].wa; ifa.wr_data = vecs[i].wd;
            ifa.ld_issue = vecs[i].li; ifa.ld_issue_addr = vecs[i].ia;
            ifa.ld_done = vecs[i].ld; ifa.ld_done_addr = vecs[i].da; ifa.ld_data = vecs[i].ldd;
            ifa.rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("v%0d rd_data0", i), 32'(ifa.rd_data[15:0]), 32'(vecs[i].ed0));
            chk($sformatf("v%0d rd_data1", i), 32'(ifa.rd_data[31:16]), 32'(vecs[i].ed1));
            chk($sformatf("v%0d rd_busy", i), 32'(ifa.rd_busy), 32'(vecs[i].ebusy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy_vec", i), 32'(ifa.busy_vec), 32'(vecs[i].ebv));
            chk($sformatf("v%0d sb_err", i), 32'(ifa.sb_err), 32'(vecs[i].eerr));
        end

        // Reset mid-load: busy cleared, the late return flags an error but still writes.
        @(negedge clk);
        idle_a(); ifa.ld_issue = 1'b1; ifa.ld_issue_addr = 3'd1;
        @(negedge clk);
        ifa.ld_issue_addr = 3'd3;
        @(negedge clk);
        idle_a();
        chk("a midload busy_vec", 32'(ifa.busy_vec), 32'h0A);
        rst_a = 1'b1; ifa.ld_issue = 1'b1; ifa.ld_issue_addr = 3'd6;
        @(negedge clk);
        rst_a = 1'b0; idle_a();
        chk("a rst busy_vec", 32'(ifa.busy_vec), 32'h00);
        chk("a rst sb_err", 32'(ifa.sb_err), 32'h0);
        ifa.rd_addr = {3'd0, 3'd3};
        #1;
        chk("a rst r3", 32'(ifa.rd_data[15:0]), 32'h0000);
        chk("a rst r0", 32'(ifa.rd_data[31:16]), 32'h0400);
        @(negedge clk);
        ifa.ld_done = 1'b1; ifa.ld_done_addr = 3'd1; ifa.ld_data = 16'h0ABC;
        @(negedge clk);
        idle_a();
        ifa.rd_addr = {3'd0, 3'd1};
        #1;
        chk("a late done sb_err", 32'(ifa.sb_err), 32'h1);
        chk("a late done r1", 32'(ifa.rd_data[15:0]), 32'h0ABC);

        // Non-bypass instance: same-cycle write is not visible.
        @(negedge clk);
        ifb.wr_en = 1'b1; ifb.wr_addr = 3'd3; ifb.wr_data = 16'hBEEF;
        read_b(3'd3, 16'h0000, 1'b0, "b nobypass");
        @(negedge clk);
        idle_b();
        read_b(3'd3, 16'hBEEF, 1'b0, "b after wr");
        // Out-of-range write and read.
        ifb.wr_en = 1'b1; ifb.wr_addr = 3'd7; ifb.wr_data = 16'hFFFF;
        @(negedge clk);
        idle_b();
        chk("b wr7 sb_err", 32'(ifb.sb_err), 32'h0);
        for (int i = 0; i < 8; i++) begin
            read_b(3'(i), (i == 0) ? 16'h0400 : ((i == 3) ? 16'hBEEF : 16'h0000), 1'b0,
                   $sformatf("b wr7 r%0d", i));
        end
        // Out-of-range issue flags an error pulse.
        @(negedge clk);
        ifb.ld_issue = 1'b1; ifb.ld_issue_addr = 3'd7;
        @(negedge clk);
        idle_b();
        chk("b issue7 sb_err", 32'(ifb.sb_err), 32'h1);
        chk("b issue7 busy_vec", 32'(ifb.busy_vec), 32'h0);
        @(negedge clk);
        chk("b issue7 pulse end", 32'(ifb.sb_err), 32'h0);
        // Raw busy with no forwarding of the returning load.
        ifb.ld_issue = 1'b1; ifb.ld_issue_addr = 3'd2;
        @(negedge clk);
        idle_b();
        chk("b ld2 busy_vec", 32'(ifb.busy_vec), 32'h04);
        ifb.ld_done = 1'b1; ifb.ld_done_addr = 3'd2; ifb.ld_data = 16'h2222;
        read_b(3'd2, 16'h0000, 1'b1, "b ld2 done");
        @(negedge clk);
        idle_b();
        chk("b ld2 cleared", 32'(ifb.busy_vec), 32'h00);
        chk("b ld2 sb_err", 32'(ifb.sb_err), 32'h0);
        read_b(3'd2, 16'h2222, 1'b0, "b ld2 data");
        // Out-of-range return flags an error.
        ifb.ld_done = 1'b1; ifb.ld_done_addr = 3'd7; ifb.ld_data = 16'h7777;
        @(negedge clk);
        idle_b();
        chk("b done7 sb_err", 32'(ifb.sb_err), 32'h1);
        // Reset with a busy bit set.
        ifb.ld_issue = 1'b1; ifb.ld_issue_addr = 3'd1;
        @(negedge clk);
        idle_b();
        chk("b pre-rst busy_vec", 32'(ifb.busy_vec), 32'h02);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("b rst busy_vec", 32'(ifb.busy_vec), 32'h00);
        read_b(3'd3, 16'h0000, 1'b0, "b rst r3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
